// File: rtl/edge_pkg.sv
// Shared types and default sizing for the debounced edge detector.
package edge_pkg;

    typedef enum logic [1:0] {
        MODE_NONE = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } edge_mode_t;

    localparam int DEF_N           = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DB_CYCLES   = 4;

endpackage

// File: rtl/edge_channel.sv
// One input channel: synchroniser, debounce counter, edge strobe and sticky pending flag.
module edge_channel
    import edge_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DB_CYCLES   = DEF_DB_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din,
    input  edge_mode_t mode,
    input  logic       clear,
    output logic       level,
    output logic       pulse,
    output logic       pending
);

    localparam int             CW       = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   s;
    logic                   upd;
    logic                   fire;

    assign s = sync_q[SYNC_STAGES-1];

    // Mode is sampled at the update edge itself, so a mode change never acts retroactively.
    always_comb begin
        upd  = (s != level) && (cnt_q == CNT_LAST);
        fire = 1'b0;
        if (upd) begin
            if (s)
                fire = (mode == MODE_RISE) || (mode == MODE_BOTH);
            else
                fire = (mode == MODE_FALL) || (mode == MODE_BOTH);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level   <= 1'b0;
            pulse   <= 1'b0;
            pending <= 1'b0;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];

            if (s == level) begin
                cnt_q <= '0;
            end else if (upd) begin
                level <= s;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end

            pulse   <= fire;
            // Set has priority over a coincident clear.
            pending <= fire | (pending & ~clear);
        end
    end

endmodule

// File: rtl/edge_detect.sv
// N independent debounced edge-detect channels with per-channel mode and pending flags.
module edge_detect
    import edge_pkg::*;
#(
    parameter int N           = DEF_N,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DB_CYCLES   = DEF_DB_CYCLES
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   in,
    input  logic [2*N-1:0] mode,
    input  logic [N-1:0]   clear,
    output logic [N-1:0]   level,
    output logic [N-1:0]   pulse,
    output logic [N-1:0]   pending
);

    for (genvar i = 0; i < N; i++) begin : g_ch
        edge_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .din     (in[i]),
            .mode    (edge_mode_t'(mode[2*i +: 2])),
            .clear   (clear[i]),
            .level   (level[i]),
            .pulse   (pulse[i]),
            .pending (pending[i])
        );
    end

endmodule
